recording_saver: RTL and testbench
==================================

// Module: recording_saver
// PURPOSE
//  Captures the live note stream from the music player into one of 8 saved-recording slots.
//  The slot is chosen by SW[2:0]. Recording starts and stops on a debounced KEY0 press.
//  KEY3 erases every slot. The recording player reads the slots back through a registered read port.
//  Sits between the music player (upstream) and the recording player (downstream) in main.
// PARAMETERS
//  TICK_DIV  2500000  clk cycles per sample tick (20 Hz at 50 MHz); must be >= 2
//  ADDR_W    8        sample-address width; DEPTH = 2**ADDR_W samples per slot
//  NOTE_W    4        note code width; code 0 = silence
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-high reset
//  note_code   in   NOTE_W    current note from music player, sampled on tick
//  rec_toggle  in   1         one-cycle pulse (KEY0 press): start/stop recording
//  clear_all   in   1         one-cycle pulse (KEY3 press): erase all slots
//  slot_sel    in   3         SW[2:0]; slot to record into, latched at start
//  rd_slot     in   3         read-port slot index
//  rd_addr     in   ADDR_W    read-port sample address
//  rd_data     out  NOTE_W    mem[rd_slot][rd_addr], 1-cycle latency
//  rd_len      out  ADDR_W+1  committed length of rd_slot (combinational), 0..DEPTH
//  slot_valid  out  8         bit i = slot i holds a committed recording (len > 0)
//  recording   out  1         high while in REC
//  wr_count    out  ADDR_W+1  samples written so far in the current take
//  full        out  1         one-cycle pulse when a take auto-stops at DEPTH
// BEHAVIOUR
//  Reset: FSM = IDLE. All slot_len = 0. slot_valid = 0, rd_data = 0, wr_count = 0. recording = 0, full = 0.
//   Tick counter = 0. Memory contents are don't-care (gated by slot_len).
//  FSM states: IDLE, REC, COMMIT.
//  IDLE: rec_toggle -> REC.
//   Latches rec_slot <= slot_sel. Sets wr_ptr = 0 and tick_cnt = 0.
//   Forces slot_len[rec_slot] = 0 and slot_valid[rec_slot] = 0 in that same cycle,
//   so a half-overwritten slot is never played.
//  REC: tick_cnt counts 0..TICK_DIV-1.
//   At tick_cnt == TICK_DIV-1: mem[rec_slot][wr_ptr] <= note_code, then wr_ptr++.
//   The first sample is therefore written TICK_DIV cycles after entry.
//   rec_toggle -> COMMIT. A partial tick is discarded; no write happens in that cycle.
//   A write that makes wr_ptr == DEPTH -> COMMIT, with full pulsed in the COMMIT cycle.
//   slot_sel changes during REC are ignored.
//  COMMIT (1 cycle): slot_len[rec_slot] <= wr_ptr. slot_valid[rec_slot] <= (wr_ptr != 0). Next state is IDLE.
//   A rec_toggle seen in COMMIT is ignored.
//  clear_all: from any state, highest priority, takes effect that cycle.
//   All slot_len <= 0, slot_valid <= 0, next state = IDLE, wr_ptr <= 0.
//   Any in-progress take is discarded and nothing is committed.
//   clear_all and rec_toggle in the same cycle: clear wins and the toggle is dropped.
//  recording = (state == REC). wr_count = wr_ptr; it holds its value after COMMIT until the next start.
//  Read port: rd_data is registered from mem[rd_slot][rd_addr] every cycle.
//   It is read-first: a read of the address being written that cycle returns the old value.
//   Reading beyond rd_len returns stale data; the consumer must bound by rd_len.
//  wr_ptr and wr_count are ADDR_W+1 bits wide, so DEPTH is representable. Write address = wr_ptr[ADDR_W-1:0].
//  reset mid-REC behaves as clear_all plus all output resets.
// TESTING (TICK_DIV=4, ADDR_W=3 => DEPTH=8)
//  1. slot_sel=2, rec_toggle, notes 5,6,7 held per tick, rec_toggle after 3 ticks + 1 cycle.
//     -> rd_len(slot2)=3, slot_valid=8'b0000_0100; rd_slot=2, addr 0..2 -> 5,6,7, each 1 cycle after the address.
//  2. Start and never stop, note=9. -> 8 writes, full pulses once, recording falls.
//     -> rd_len=8, wr_count=8, and a further rec_toggle starts a new take.
//  3. Record slot 1 (len 3), then re-record slot 1 and stop immediately.
//     -> slot_valid[1]=0 from the start cycle on; after COMMIT rd_len=0.
//  4. Slots 0 and 3 recorded; clear_all pulsed during a REC take into slot 5.
//     -> next cycle state IDLE, slot_valid=0, all rd_len=0.
//  5. clear_all and rec_toggle in the same IDLE cycle -> stays IDLE, recording=0.
//  6. Assert reset for 1 cycle mid-REC at wr_count=2.
//     -> all outputs at reset values next cycle; slot being recorded has rd_len=0.

Source files
------------

// File: rtl/recording_saver_if.sv
// Bundle of the note-capture, control and read-back signals of recording_saver.
// master = surrounding system (music player / keys / recording player), slave = the saver.
interface recording_saver_if #(
    parameter int ADDR_W = 8,
    parameter int NOTE_W = 4
);
    logic [NOTE_W-1:0] note_code;
    logic              rec_toggle;
    logic              clear_all;
    logic [2:0]        slot_sel;
    logic [2:0]        rd_slot;
    logic [ADDR_W-1:0] rd_addr;
    logic [NOTE_W-1:0] rd_data;
    logic [ADDR_W:0]   rd_len;
    logic [7:0]        slot_valid;
    logic              recording;
    logic [ADDR_W:0]   wr_count;
    logic              full;

    modport master (
        output note_code, rec_toggle, clear_all, slot_sel, rd_slot, rd_addr,
        input  rd_data, rd_len, slot_valid, recording, wr_count, full
    );

    modport slave (
        input  note_code, rec_toggle, clear_all, slot_sel, rd_slot, rd_addr,
        output rd_data, rd_len, slot_valid, recording, wr_count, full
    );
endinterface

// File: rtl/recording_saver.sv
// Captures the live note stream into one of 8 recording slots, one sample per tick,
// and serves the slots back through a registered read-first port.
module recording_saver #(
    parameter int TICK_DIV = 2500000,
    parameter int ADDR_W   = 8,
    parameter int NOTE_W   = 4
) (
    input logic          clk,
    input logic          reset,
    recording_saver_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int IDX_W  = ADDR_W + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_COMMIT
    } state_t;

    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [2:0]        r_rec_slot;
    logic [ADDR_W:0]   r_slot_len [8];
    logic [7:0]        r_slot_valid;
    logic              r_recording;
    logic              r_full;
    logic [NOTE_W-1:0] r_rd_data;
    logic [NOTE_W-1:0] r_mem [8*DEPTH];

    logic              w_tick_done;
    logic              w_wr_en;
    logic [ADDR_W:0]   w_ptr_next;
    logic [ADDR_W:0]   w_depth;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;

    always_comb begin
        w_depth     = DEPTH[ADDR_W:0];
        w_tick_done = (r_tick == TICK_W'(TICK_DIV - 1));
        w_ptr_next  = r_wr_ptr + (ADDR_W + 1)'(1);
        w_wr_idx    = {r_rec_slot, r_wr_ptr[ADDR_W-1:0]};
        w_rd_idx    = {bus.rd_slot, bus.rd_addr};
        // A stop request or clear on the tick cycle discards that sample.
        w_wr_en     = (r_state == S_REC) && w_tick_done &&
                      !bus.rec_toggle && !bus.clear_all && !reset;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.note_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_wr_ptr     <= '0;
            r_rec_slot   <= '0;
            r_slot_valid <= '0;
            r_recording  <= 1'b0;
            r_full       <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_slot_len[i] <= '0;
            end
        end else begin
            r_full <= 1'b0;
            if (bus.clear_all) begin
                r_state      <= S_IDLE;
                r_wr_ptr     <= '0;
                r_tick       <= '0;
                r_slot_valid <= '0;
                r_recording  <= 1'b0;
                for (int unsigned i = 0; i < 8; i++) begin
                    r_slot_len[i] <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.rec_toggle) begin
                            // Invalidate the target slot immediately so a partly
                            // overwritten take can never be played back.
                            r_state                    <= S_REC;
                            r_rec_slot                 <= bus.slot_sel;
                            r_wr_ptr                   <= '0;
                            r_tick                     <= '0;
                            r_slot_len[bus.slot_sel]   <= '0;
                            r_slot_valid[bus.slot_sel] <= 1'b0;
                            r_recording                <= 1'b1;
                        end
                    end
                    S_REC: begin
                        if (bus.rec_toggle) begin
                            r_state     <= S_COMMIT;
                            r_recording <= 1'b0;
                        end else if (w_tick_done) begin
                            r_tick   <= '0;
                            r_wr_ptr <= w_ptr_next;
                            if (w_ptr_next == w_depth) begin
                                r_state     <= S_COMMIT;
                                r_recording <= 1'b0;
                                r_full      <= 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + TICK_W'(1);
                        end
                    end
                    S_COMMIT: begin
                        r_slot_len[r_rec_slot]   <= r_wr_ptr;
                        r_slot_valid[r_rec_slot] <= (r_wr_ptr != '0);
                        r_state                  <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_len     = r_slot_len[bus.rd_slot];
    assign bus.slot_valid = r_slot_valid;
    assign bus.recording  = r_recording;
    assign bus.wr_count   = r_wr_ptr;
    assign bus.full       = r_full;
endmodule

// File: tb/tb_recording_saver.sv
// Directed bench for recording_saver: a take-level model predicts every output each cycle,
// and literal checks pin the model at the key points of each scenario.
module tb_recording_saver;
    localparam int TICK_DIV = 4;
    localparam int ADDR_W   = 3;
    localparam int NOTE_W   = 4;
    localparam int DEPTH    = 8;

    logic clk;
    logic reset;

    recording_saver_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W)) bus ();

    recording_saver #(
        .TICK_DIV(TICK_DIV),
        .ADDR_W  (ADDR_W),
        .NOTE_W  (NOTE_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Take-level model: a take is active, counts cycles since start and stores
    // one sample every TICK_DIV-th cycle; a finished take commits one cycle later.
    bit         m_rec;
    bit         m_commit;
    bit         m_full;
    int         m_phase;
    int         m_ptr;
    int         m_slot;
    int         m_len [8];
    logic [3:0] m_mem [8][DEPTH];
    bit         m_known [8][DEPTH];
    logic [3:0] exp_rd;
    bit         exp_rd_known;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit full_next;
        int rs, ra;
        rs = int'(bus.rd_slot);
        ra = int'(bus.rd_addr);
        exp_rd       = m_mem[rs][ra];
        exp_rd_known = m_known[rs][ra];
        full_next    = 0;
        if (reset) begin
            exp_rd = 4'd0;
            exp_rd_known = 1;
            m_rec = 0; m_commit = 0; m_ptr = 0;
            foreach (m_len[i]) m_len[i] = 0;
        end else if (bus.clear_all) begin
            m_rec = 0; m_commit = 0; m_ptr = 0;
            foreach (m_len[i]) m_len[i] = 0;
        end else if (m_commit) begin
            m_len[m_slot] = m_ptr;
            m_commit = 0;
        end else if (m_rec) begin
            if (bus.rec_toggle) begin
                m_rec = 0; m_commit = 1;
            end else begin
                m_phase++;
                if (m_phase % TICK_DIV == 0) begin
                    m_mem[m_slot][m_ptr]   = bus.note_code;
                    m_known[m_slot][m_ptr] = 1;
                    m_ptr++;
                    if (m_ptr == DEPTH) begin
                        m_rec = 0; m_commit = 1; full_next = 1;
                    end
                end
            end
        end else if (bus.rec_toggle) begin
            m_rec = 1;
            m_slot = int'(bus.slot_sel);
            m_ptr = 0;
            m_phase = 0;
            m_len[m_slot] = 0;
        end
        m_full = full_next;
    endtask

    task automatic compare();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i] = (m_len[i] != 0);
        chk("recording", bus.recording, m_rec);
        chk("wr_count", bus.wr_count, m_ptr);
        chk("full", bus.full, m_full);
        chk("slot_valid", bus.slot_valid, v);
        chk("rd_len", bus.rd_len, m_len[bus.rd_slot]);
        if (exp_rd_known) chk("rd_data", bus.rd_data, exp_rd);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic pulse_tog();
        bus.rec_toggle = 1'b1;
        step();
        bus.rec_toggle = 1'b0;
    endtask

    task automatic take(input int slot, input int nticks, input int note);
        bus.slot_sel = slot[2:0];
        pulse_tog();
        bus.note_code = note[3:0];
        repeat (nticks * TICK_DIV) step();
        pulse_tog();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_notes [3];
        int fulls;
        bit reached;
        exp_notes[0] = 5; exp_notes[1] = 6; exp_notes[2] = 7;
        foreach (m_known[i, j]) m_known[i][j] = 0;
        reset = 1'b1;
        bus.note_code = '0; bus.rec_toggle = 1'b0; bus.clear_all = 1'b0;
        bus.slot_sel = '0; bus.rd_slot = '0; bus.rd_addr = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_recording", bus.recording, 0);
        chk("rst_slot_valid", bus.slot_valid, 0);
        chk("rst_wr_count", bus.wr_count, 0);
        chk("rst_rd_data", bus.rd_data, 0);

        // 1: three ticks of 5,6,7 into slot 2, stop one cycle after the third tick
        bus.slot_sel = 3'd2;
        pulse_tog();
        for (int n = 5; n <= 7; n++) begin
            bus.note_code = n[3:0];
            repeat (TICK_DIV) step();
        end
        step();
        pulse_tog();
        step();
        bus.rd_slot = 3'd2;
        #1;
        chk("t1_rd_len", bus.rd_len, 3);
        chk("t1_slot_valid", bus.slot_valid, 8'b0000_0100);
        for (int a = 0; a < 3; a++) begin
            bus.rd_addr = a[2:0];
            step();
            chk("t1_rd_data", bus.rd_data, exp_notes[a]);
        end

        // 2: never stopped, auto-stop at DEPTH; reads addr 1 while it is overwritten
        bus.rd_addr = 3'd1;
        pulse_tog();
        bus.note_code = 4'd9;
        fulls = 0;
        repeat (40) begin
            step();
            if (bus.full) fulls++;
        end
        chk("t2_full_pulses", fulls, 1);
        chk("t2_recording", bus.recording, 0);
        chk("t2_wr_count", bus.wr_count, 8);
        chk("t2_rd_len", bus.rd_len, 8);
        pulse_tog();
        chk("t2_restart", bus.recording, 1);
        chk("t2_restart_cnt", bus.wr_count, 0);
        pulse_tog();
        step();

        // 3: slot 1 len 3 (toggle in COMMIT ignored), then re-record and stop at once
        bus.slot_sel = 3'd1;
        pulse_tog();
        bus.note_code = 4'd3;
        repeat (3 * TICK_DIV) step();
        pulse_tog();
        bus.rec_toggle = 1'b1;
        step();
        bus.rec_toggle = 1'b0;
        step();
        chk("t3_commit_tog", bus.recording, 0);
        bus.rd_slot = 3'd1;
        #1;
        chk("t3_len_first", bus.rd_len, 3);
        pulse_tog();
        chk("t3_valid_drop", bus.slot_valid[1], 0);
        pulse_tog();
        step();
        chk("t3_len_empty", bus.rd_len, 0);

        // 4: slots 0 and 3 committed, clear_all mid take into slot 5
        take(0, 2, 4);
        take(3, 1, 11);
        chk("t4_valid", bus.slot_valid, 8'b0000_1001);
        bus.slot_sel = 3'd5;
        pulse_tog();
        repeat (6) step();
        bus.clear_all = 1'b1;
        step();
        bus.clear_all = 1'b0;
        chk("t4_recording", bus.recording, 0);
        chk("t4_valid_clr", bus.slot_valid, 0);
        for (int s = 0; s < 8; s++) begin
            bus.rd_slot = s[2:0];
            #1;
            chk("t4_rd_len", bus.rd_len, 0);
        end
        step();

        // 5: clear_all and rec_toggle together in IDLE
        bus.clear_all = 1'b1;
        bus.rec_toggle = 1'b1;
        step();
        bus.clear_all = 1'b0;
        bus.rec_toggle = 1'b0;
        chk("t5_recording", bus.recording, 0);
        step();
        chk("t5_recording2", bus.recording, 0);

        // 6: reset mid take at wr_count 2
        take(7, 1, 2);
        bus.slot_sel = 3'd4;
        bus.rd_slot = 3'd4;
        pulse_tog();
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            step();
            if (bus.wr_count == 2) reached = 1;
        end
        chk("t6_reach_cnt2", reached, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_recording", bus.recording, 0);
        chk("t6_wr_count", bus.wr_count, 0);
        chk("t6_slot_valid", bus.slot_valid, 0);
        chk("t6_rd_data", bus.rd_data, 0);
        chk("t6_rd_len", bus.rd_len, 0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
